spi_flash_responder: RTL and testbench



---
 rtl/spi_flash_pkg.sv | 51 +++++
 rtl/spi_flash_sync_edge.sv | 47 ++++
 rtl/spi_flash_responder.sv | 279 +++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states,
// status register layout and small byte-selection helpers.
package spi_flash_pkg;

    // Supported 25-series opcodes
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_PP        = 8'h02;
    localparam logic [7:0] CMD_RDSR      = 8'h05;
    localparam logic [7:0] CMD_RDID      = 8'h9F;
    localparam logic [7:0] CMD_WREN      = 8'h06;
    localparam logic [7:0] CMD_WRDI      = 8'h04;

    // Status register bit positions
    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_STATUS,
        ST_JEDEC,
        ST_IGNORE
    } state_e;

    // Byte idx of the ID response: 0..2 walk the ID MSB first, 3 is the 00h tail.
    function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[23:16];
            2'd1:    b = id[15:8];
            2'd2:    b = id[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Status register image as shifted out by RDSR.
    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s         = 8'h00;
        s[SR_WEL] = wel;
        s[SR_WIP] = wip;
        return s;
    endfunction

endpackage

// File: rtl/spi_flash_sync_edge.sv
// Brings the asynchronous SPI pins into the clk_48mhz domain through
// 2-flop synchronizers and derives single-cycle sck/cs edge pulses.
// sck and mosi share the same pipeline depth, so a sampled mosi value
// lines up with the sck rise pulse that qualifies it.
module spi_flash_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_i,
    input  logic cs_i,
    input  logic mosi_i,
    output logic mosi_o,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_rise_o,
    output logic cs_fall_o
);

    logic [1:0] sck_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sck_prev_q;
    logic       cs_prev_q;

    // Synchronizer chains plus one history flop each for edge detection; cs idles high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sck_sync_q  <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            cs_sync_q   <= {cs_sync_q[0], cs_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            sck_prev_q  <= sck_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    assign mosi_o     = mosi_sync_q[1];
    assign sck_rise_o =  sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall_o = ~sck_sync_q[1] &  sck_prev_q;
    assign cs_rise_o  =  cs_sync_q[1]  & ~cs_prev_q;
    assign cs_fall_o  = ~cs_sync_q[1]  &  cs_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target: decodes READ, FAST_READ, PP, RDSR, RDID,
// WREN and WRDI and serves them from an external byte-wide memory.
//
// Memory port protocol: mem_rd_en is a one-cycle request and mem_rdata is
// taken exactly one cycle later with no back-pressure; mem_wr_en is a
// one-cycle write with mem_addr/mem_wdata stable in that cycle. The two
// strobes are never high together.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          ADDR_W      = 16,
    parameter int          PROG_CYCLES = 4800
) (
    input  logic              clk_48mhz,
    input  logic              resetn,
    input  logic              spi_sck,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(PROG_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    // Synchronized pins and edge pulses
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    spi_flash_sync_edge u_sync (
        .clk_i      (clk_48mhz),
        .rst_ni     (resetn),
        .sck_i      (spi_sck),
        .cs_i       (spi_cs),
        .mosi_i     (spi_mosi),
        .mosi_o     (mosi_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_rise_o  (cs_rise),
        .cs_fall_o  (cs_fall)
    );

    // FSM state
    state_e state_q;
    state_e state_d;

    // Datapath registers
    logic [7:0]        sr_in_q;      // incoming bits of the current byte
    logic [2:0]        bit_cnt_q;    // bits received in the current byte
    logic [1:0]        addr_byte_q;  // address bytes received so far
    logic [7:0]        cmd_q;        // latched opcode
    logic [7:0]        out_q;        // outgoing shift register
    logic [2:0]        out_cnt_q;    // bits presented of the current out byte
    logic [1:0]        jedec_idx_q;  // next ID byte to load
    logic              miso_q;
    logic              oe_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;
    logic              load_q;       // mem_rdata is valid this cycle
    logic              wr_en_q;
    logic [7:0]        wdata_q;
    logic              written_q;    // at least one byte programmed this cs cycle
    logic              wel_q;
    logic              wip_q;
    logic [CNT_W-1:0]  prog_cnt_q;

    // Decoded controls
    logic       shift_in_st;
    logic       resp_st;
    logic       byte_done;
    logic [7:0] byte_in;

    assign byte_in   = {sr_in_q[6:0], mosi_s};
    assign byte_done = sck_rise && shift_in_st && (bit_cnt_q == 3'd7);

    // State register
    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: cs rise always wins; otherwise advance on completed bytes
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (byte_done) begin
                        if (wip_q && (byte_in != CMD_RDSR)) begin
                            state_d = ST_IGNORE;
                        end else begin
                            case (byte_in)
                                CMD_READ, CMD_FAST_READ, CMD_PP: state_d = ST_ADDR;
                                CMD_RDSR:                        state_d = ST_STATUS;
                                CMD_RDID:                        state_d = ST_JEDEC;
                                default:                         state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done && (addr_byte_q == 2'd2)) begin
                        if (cmd_q == CMD_FAST_READ)  state_d = ST_DUMMY;
                        else if (cmd_q == CMD_READ)  state_d = ST_RD_DATA;
                        else if (wel_q)              state_d = ST_WR_DATA;
                        else                         state_d = ST_IGNORE;
                    end
                end
                ST_DUMMY: begin
                    if (byte_done) state_d = ST_RD_DATA;
                end
                default: ;
            endcase
        end
    end

    // Output decode: which states shift mosi in and which drive miso
    always_comb begin
        shift_in_st = 1'b0;
        resp_st     = 1'b0;
        case (state_q)
            ST_CMD, ST_ADDR, ST_DUMMY, ST_WR_DATA: shift_in_st = 1'b1;
            ST_RD_DATA, ST_STATUS, ST_JEDEC:       resp_st     = 1'b1;
            default: ;
        endcase
    end

    // Datapath: bit shifting, memory strobes, status bits and program timer
    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            sr_in_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            addr_byte_q <= 2'd0;
            cmd_q       <= 8'h00;
            out_q       <= 8'h00;
            out_cnt_q   <= 3'd0;
            jedec_idx_q <= 2'd0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            load_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wdata_q     <= 8'h00;
            written_q   <= 1'b0;
            wel_q       <= 1'b0;
            wip_q       <= 1'b0;
            prog_cnt_q  <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            load_q  <= rd_en_q;

            if (load_q) out_q <= mem_rdata;

            // Page program advances only the low address byte, one cycle after each strobe
            if (wr_en_q) addr_q[7:0] <= addr_q[7:0] + 8'd1;

            if (wip_q) begin
                if (prog_cnt_q <= CNT_W'(1)) begin
                    wip_q      <= 1'b0;
                    prog_cnt_q <= '0;
                end else begin
                    prog_cnt_q <= prog_cnt_q - CNT_W'(1);
                end
            end

            if (cs_rise) begin
                bit_cnt_q <= 3'd0;
                out_cnt_q <= 3'd0;
                oe_q      <= 1'b0;
                miso_q    <= 1'b0;
                if ((state_q == ST_WR_DATA) && written_q) begin
                    wel_q      <= 1'b0;
                    wip_q      <= 1'b1;
                    prog_cnt_q <= CNT_W'(PROG_CYCLES);
                end
            end else begin
                if (cs_fall) begin
                    bit_cnt_q   <= 3'd0;
                    out_cnt_q   <= 3'd0;
                    addr_byte_q <= 2'd0;
                    written_q   <= 1'b0;
                end

                if (sck_rise && shift_in_st) begin
                    sr_in_q   <= byte_in;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end

                // Keep only the last ADDR_W bits of the 24-bit address
                if (sck_rise && (state_q == ST_ADDR)) begin
                    addr_q <= {addr_q[ADDR_W-2:0], mosi_s};
                end

                if (byte_done) begin
                    case (state_q)
                        ST_CMD: begin
                            cmd_q <= byte_in;
                            if (!wip_q) begin
                                case (byte_in)
                                    CMD_WREN: wel_q <= 1'b1;
                                    CMD_WRDI: wel_q <= 1'b0;
                                    CMD_RDID: begin
                                        out_q       <= jedec_byte(JEDEC_ID, 2'd0);
                                        jedec_idx_q <= 2'd1;
                                    end
                                    default: ;
                                endcase
                            end
                            if (byte_in == CMD_RDSR) out_q <= status_byte(wel_q, wip_q);
                        end
                        ST_ADDR: begin
                            addr_byte_q <= addr_byte_q + 2'd1;
                            if ((addr_byte_q == 2'd2) && (cmd_q == CMD_READ)) rd_en_q <= 1'b1;
                        end
                        ST_DUMMY: rd_en_q <= 1'b1;
                        ST_WR_DATA: begin
                            wr_en_q   <= 1'b1;
                            wdata_q   <= byte_in;
                            written_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end

                // Present the next bit on each fall; reload after the 8th bit of a byte
                if (sck_fall && resp_st) begin
                    miso_q    <= out_q[7];
                    oe_q      <= 1'b1;
                    out_cnt_q <= out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) begin
                        case (state_q)
                            ST_STATUS: out_q <= status_byte(wel_q, wip_q);
                            ST_JEDEC: begin
                                out_q <= jedec_byte(JEDEC_ID, jedec_idx_q);
                                if (jedec_idx_q != 2'd3) jedec_idx_q <= jedec_idx_q + 2'd1;
                            end
                            default: begin
                                out_q   <= {out_q[6:0], 1'b0};
                                addr_q  <= addr_q + ADDR_ONE;
                                rd_en_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        out_q <= {out_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wdata   = wdata_q;
    assign busy        = wip_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder: an SPI master driver, a memory
// model behind the memory port, a flash reference model, and monitors that
// compare response bytes and write strobes against expected queues.
module tb_spi_flash_responder;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_48mhz = 1'b0;
    logic        resetn    = 1'b0;
    logic        spi_sck   = 1'b0;
    logic        spi_cs    = 1'b1;
    logic        spi_mosi  = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_wr_en;
    logic [7:0]  mem_wdata;
    logic        busy;

    always #10 clk_48mhz = ~clk_48mhz;

    spi_flash_responder dut (
        .clk_48mhz   (clk_48mhz),
        .resetn      (resetn),
        .spi_sck     (spi_sck),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .mem_wr_en   (mem_wr_en),
        .mem_wdata   (mem_wdata),
        .busy        (busy)
    );

    // External memory seen by the DUT (1-cycle read latency)
    logic [7:0] mem     [0:65535];
    // Reference image of what the memory should contain
    logic [7:0] ref_mem [0:65535];

    always @(posedge clk_48mhz) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    // ---------------- scoreboard state ----------------
    logic [7:0]  exp_q[$];     // expected response bytes on miso
    logic [23:0] wr_exp_q[$];  // expected writes {addr, data}
    logic [7:0]  prog_data[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rd_count = 0;
    int wr_count = 0;
    int overlap  = 0;
    int busy_run = 0;
    int last_run = 0;
    logic mon_en = 1'b0;
    int half = 6;

    // Reference model of the flash status bits
    logic m_wel = 1'b0;
    logic m_wip = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- monitors ----------------
    // Response monitor: assembles bits on every sck rise while a response is clocked
    initial begin : resp_monitor
        logic [7:0] sh;
        int nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge spi_sck);
            if (!mon_en) begin
                nb = 0;
            end else begin
                sh = {sh[6:0], spi_miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    check("resp_oe", spi_miso_oe, 1);
                    check("resp_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("resp_byte", sh, exp_q.pop_front());
                end
            end
        end
    end

    // Memory-port monitor: write strobes against expectations, strobe counts, busy runs
    initial begin : mem_monitor
        forever begin
            @(negedge clk_48mhz);
            if (mem_rd_en) rd_count++;
            if (mem_rd_en && mem_wr_en) overlap++;
            if (mem_wr_en) begin
                wr_count++;
                check("write_expected", wr_exp_q.size() != 0, 1);
                if (wr_exp_q.size() != 0) check("write", {mem_addr, mem_wdata}, wr_exp_q.pop_front());
            end
            if (!resetn) busy_run = 0;
            else if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_run = busy_run;
                busy_run = 0;
            end
        end
    end

    initial begin : watchdog
        #(80000 * 20);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic spi_bit(input logic b);
        spi_mosi = b;
        repeat (half) @(negedge clk_48mhz);
        spi_sck = 1'b1;
        repeat (half) @(negedge clk_48mhz);
        spi_sck = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) spi_bit(b[i]);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
    endtask

    task automatic cs_start();
        half = $urandom_range(5, 8);
        @(negedge clk_48mhz);
        spi_cs = 1'b0;
        repeat (half) @(negedge clk_48mhz);
    endtask

    task automatic cs_end();
        repeat (half) @(negedge clk_48mhz);
        spi_cs = 1'b1;
        repeat (16) @(negedge clk_48mhz);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        spi_byte(cmd);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
    endtask

    task automatic clock_resp(input int n);
        mon_en = 1'b1;
        for (int i = 0; i < n; i++) spi_byte(8'($urandom_range(0, 255)));
        mon_en = 1'b0;
    endtask

    // ---------------- model-driven transactions ----------------
    task automatic do_read(input logic [23:0] a, input int n, input bit fast);
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(int'(a[15:0]) + i) % 65536]);
        cs_start();
        send_hdr(fast ? 8'h0B : 8'h03, a);
        if (fast) spi_byte(8'($urandom_range(0, 255)));
        clock_resp(n);
        cs_end();
    endtask

    task automatic do_status(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({6'b0, m_wel, m_wip});
        cs_start();
        spi_byte(8'h05);
        clock_resp(n);
        cs_end();
    endtask

    task automatic do_jedec(input int n);
        logic [23:0] id;
        id = 24'hEF4016;
        for (int i = 0; i < n; i++) exp_q.push_back((i < 3) ? id[23 - 8 * i -: 8] : 8'h00);
        cs_start();
        spi_byte(8'h9F);
        clock_resp(n);
        cs_end();
    endtask

    task automatic do_simple(input logic [7:0] cmd);
        cs_start();
        spi_byte(cmd);
        cs_end();
        if (!m_wip) begin
            if (cmd == 8'h06) m_wel = 1'b1;
            if (cmd == 8'h04) m_wel = 1'b0;
        end
    endtask

    task automatic do_program(input logic [23:0] a);
        logic [15:0] wa;
        int n;
        n = prog_data.size();
        if (m_wel && !m_wip) begin
            for (int i = 0; i < n; i++) begin
                wa = {a[15:8], 8'((int'(a[7:0]) + i) % 256)};
                wr_exp_q.push_back({wa, prog_data[i]});
                ref_mem[wa] = prog_data[i];
            end
        end
        cs_start();
        send_hdr(8'h02, a);
        for (int i = 0; i < n; i++) spi_byte(prog_data[i]);
        cs_end();
        if (m_wel && !m_wip && n > 0) begin
            m_wel = 1'b0;
            m_wip = 1'b1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int rd0;
        int wr0;
        int op;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16'h0123] = 8'hAA; ref_mem[16'h0123] = 8'hAA;
        mem[16'h0124] = 8'h55; ref_mem[16'h0124] = 8'h55;
        mem[16'h0125] = 8'hC3; ref_mem[16'h0125] = 8'hC3;
        mem[16'hFFFF] = 8'h11; ref_mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22; ref_mem[16'h0000] = 8'h22;

        // Reset state
        repeat (4) @(negedge clk_48mhz);
        check("rst_miso", spi_miso, 0);
        check("rst_oe", spi_miso_oe, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk_48mhz);

        // Plain read, strobe count includes the prefetch of the 4th byte
        rd0 = rd_count;
        do_read(24'h000123, 3, 1'b0);
        check("read_strobes", rd_count - rd0, 4);

        // Fast read across the top of memory
        do_read(24'h00FFFF, 2, 1'b1);

        // Page program with wrap, then WIP window
        do_simple(8'h06);
        do_status(1);
        prog_data = '{8'hDE, 8'hAD, 8'hBE};
        do_program(24'h0012FE);
        do_status(2);
        do_simple(8'h06);  // must be ignored while WIP
        for (int k = 0; k < 6000 && busy; k++) @(negedge clk_48mhz);
        check("busy_cleared", busy, 0);
        repeat (2) @(negedge clk_48mhz);
        check("busy_cycles", last_run, 4800);
        m_wip = 1'b0;
        do_status(1);
        do_read(24'h0012FE, 2, 1'b0);
        do_read(24'h001200, 1, 1'b0);

        // Write protection
        wr0 = wr_count;
        prog_data = '{8'h77};
        do_program(24'h000010);
        check("wp_no_write", wr_count - wr0, 0);
        do_status(1);
        do_read(24'h000010, 1, 1'b0);

        // JEDEC ID
        do_jedec(5);

        // Abort a data byte after 5 bits: no write, WEL kept, WIP untouched
        do_simple(8'h06);
        wr0 = wr_count;
        cs_start();
        send_hdr(8'h02, 24'h000040);
        spi_bits(8'hA5, 5);
        cs_end();
        check("abort_no_write", wr_count - wr0, 0);
        check("abort_busy", busy, 0);
        do_status(1);

        // Reset in the middle of a read
        exp_q.push_back(ref_mem[16'h0123]);
        cs_start();
        send_hdr(8'h03, 24'h000123);
        clock_resp(1);
        spi_bits(8'h00, 3);
        @(negedge clk_48mhz);
        check("pre_reset_oe", spi_miso_oe, 1);
        resetn = 1'b0;
        @(negedge clk_48mhz);
        check("reset_oe", spi_miso_oe, 0);
        check("reset_rd_en", mem_rd_en, 0);
        spi_cs  = 1'b1;
        spi_sck = 1'b0;
        repeat (3) @(negedge clk_48mhz);
        resetn = 1'b1;
        m_wel  = 1'b0;
        m_wip  = 1'b0;
        repeat (5) @(negedge clk_48mhz);
        do_status(1);

        // Randomized mix of transactions
        for (int t = 0; t < 10; t++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: do_read(24'($urandom), $urandom_range(1, 4), 1'b0);
                1: do_read(24'($urandom), $urandom_range(1, 4), 1'b1);
                2: do_status($urandom_range(1, 3));
                3: do_jedec($urandom_range(1, 5));
                default: begin
                    do_simple(($urandom_range(0, 1) != 0) ? 8'h06 : 8'h04);
                    do_status(1);
                end
            endcase
        end

        repeat (20) @(negedge clk_48mhz);
        check("resp_queue_drained", exp_q.size(), 0);
        check("wr_queue_drained", wr_exp_q.size(), 0);
        check("rd_wr_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
